// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges the unstallable ALU result and buffered load responses
// into one registered register-file write per cycle. Define WB_FWD_EN for decode bypass ports.
module wb_arbiter #(
  parameter int LD_FIFO_DEPTH = 4,
  parameter int CNT_W         = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             alu_valid,
  input  logic [4:0]       alu_rd,
  input  logic [31:0]      alu_data,
  input  logic             ld_valid,
  output logic             ld_ready,
  input  logic [4:0]       ld_rd,
  input  logic [31:0]      ld_data,
  output logic             rf_we,
  output logic [4:0]       rf_waddr,
  output logic [31:0]      rf_wdata,
  output logic [CNT_W-1:0] ld_count,
`ifdef WB_FWD_EN
  input  logic [4:0]       fwd_raddr1,
  input  logic [4:0]       fwd_raddr2,
  output logic             fwd_hit1,
  output logic             fwd_hit2,
  output logic [31:0]      fwd_data1,
  output logic [31:0]      fwd_data2,
`endif
  output logic             wb_busy
);

  localparam int PTR_W = (LD_FIFO_DEPTH > 1) ? $clog2(LD_FIFO_DEPTH) : 1;

  logic [4:0]       fifo_rd   [LD_FIFO_DEPTH];
  logic [31:0]      fifo_data [LD_FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             fifo_full;
  logic             fifo_empty;
  logic             ld_push;
  logic             ld_pop;

  // ld_ready depends only on registered occupancy, so a full FIFO never accepts
  // a push even when the head is popped in the same cycle.
  assign fifo_full  = (ld_count == CNT_W'(LD_FIFO_DEPTH));
  assign fifo_empty = (ld_count == '0);
  assign ld_ready   = !fifo_full;
  assign ld_push    = ld_valid && ld_ready && (ld_rd != 5'd0);
  assign ld_pop     = !alu_valid && !fifo_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      ld_count <= '0;
    end else begin
      if (ld_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (ld_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({ld_push, ld_pop})
        2'b10:   ld_count <= ld_count + CNT_W'(1);
        2'b01:   ld_count <= ld_count - CNT_W'(1);
        default: ld_count <= ld_count;
      endcase
    end
  end

  // Payload storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (ld_push) begin
      fifo_rd[wr_ptr]   <= ld_rd;
      fifo_data[wr_ptr] <= ld_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we    <= 1'b0;
      rf_waddr <= 5'd0;
      rf_wdata <= 32'd0;
    end else if (alu_valid) begin
      rf_we    <= (alu_rd != 5'd0);
      rf_waddr <= alu_rd;
      rf_wdata <= alu_data;
    end else if (!fifo_empty) begin
      rf_we    <= 1'b1;
      rf_waddr <= fifo_rd[rd_ptr];
      rf_wdata <= fifo_data[rd_ptr];
    end else begin
      rf_we    <= 1'b0;
    end
  end

  assign wb_busy = !fifo_empty || rf_we;

`ifdef WB_FWD_EN
  // Lets decode see the value the register file commits at the next edge.
  assign fwd_hit1  = rf_we && (rf_waddr == fwd_raddr1) && (fwd_raddr1 != 5'd0);
  assign fwd_hit2  = rf_we && (rf_waddr == fwd_raddr2) && (fwd_raddr2 != 5'd0);
  assign fwd_data1 = fwd_hit1 ? rf_wdata : 32'd0;
  assign fwd_data2 = fwd_hit2 ? rf_wdata : 32'd0;
`endif

endmodule
